// File: rtl/alu_seq_pkg.sv
// Shared types for the nibble-serial ALU controller: opcodes, FSM states, flag bundle.
package alu_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_NOT = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SLICE1 = 2'd1,
    ST_SLICE2 = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic c;
  } flags_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command/result handshake bundle for alu_seq_ctrl.
// cmd_use_acc exists only when ALU_SEQ_ACC_EN is defined.
interface alu_seq_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
`ifdef ALU_SEQ_ACC_EN
  logic       cmd_use_acc;
`endif
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_flags;
  logic       res_err;
  logic       busy;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
`ifdef ALU_SEQ_ACC_EN
    output cmd_use_acc,
`endif
    output res_ready,
    input  cmd_ready, res_valid, res_data, res_flags, res_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
`ifdef ALU_SEQ_ACC_EN
    input  cmd_use_acc,
`endif
    input  res_ready,
    output cmd_ready, res_valid, res_data, res_flags, res_err, busy
  );
endinterface

// File: rtl/alu_seq_ctrl_slice4.sv
// Combinational 4-bit ALU slice. For shifts, cin is the bit shifted in and
// cout the bit shifted out, so two chained passes form an 8-bit shift.
module alu_slice4
  import alu_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  op_e              op,
  input  logic             cin,
  output logic [NIB_W-1:0] y,
  output logic             cout
);

  always_comb begin
    y    = '0;
    cout = 1'b0;
    case (op)
      OP_ADD: {cout, y} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
      OP_SUB: {cout, y} = {1'b0, a} + {1'b0, ~b} + {{NIB_W{1'b0}}, cin};
      OP_NOT: y = ~a;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        y    = {a[NIB_W-2:0], cin};
        cout = a[NIB_W-1];
      end
      OP_SHR: begin
        y    = {cin, a[NIB_W-1:1]};
        cout = a[0];
      end
      default: begin
        y    = '0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer running 8-bit ALU ops as two passes through one 4-bit slice.
// Optional accumulator operand enabled by defining ALU_SEQ_ACC_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | ready for a command
// ST_SLICE1 | first nibble (high nibble for SHR, else low)
// ST_SLICE2 | second nibble, carry chained from SLICE1; result latched
// ST_DONE   | result held until res_ready
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter logic [7:0] MASK_OPS = 8'hFF
) (
  input  logic hz100,
  input  logic reset_n,
  alu_seq_ctrl_if.slave bus
);

  state_e           state, state_nx;
  op_e              op_q;
  logic [7:0]       a_q, b_q, op_a, res_q, res_full;
  logic [NIB_W-1:0] y1_q, s_a, s_b, s_y;
  logic             c1_q, s_cin, s_cout;
  logic             err_q, accept, legal, pass2, take_hi, hi_first;
  flags_t           flags_q, flags_nx;
`ifdef ALU_SEQ_ACC_EN
  logic [7:0]       acc_q;
`endif

  assign accept = bus.cmd_valid && (state == ST_IDLE);
  assign legal  = MASK_OPS[bus.cmd_op];

`ifdef ALU_SEQ_ACC_EN
  assign op_a = bus.cmd_use_acc ? acc_q : bus.cmd_a;
`else
  assign op_a = bus.cmd_a;
`endif

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (bus.cmd_valid) state_nx = legal ? ST_SLICE1 : ST_DONE;
      ST_SLICE1: state_nx = ST_SLICE2;
      ST_SLICE2: state_nx = ST_DONE;
      ST_DONE:   if (bus.res_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state == ST_IDLE);
    bus.busy      = (state != ST_IDLE);
    bus.res_valid = (state == ST_DONE);
  end

  // SHR walks high-to-low so the bit crossing the nibble boundary flows via carry
  assign hi_first = (op_q == OP_SHR);
  assign pass2    = (state == ST_SLICE2);
  assign take_hi  = hi_first ^ pass2;
  assign s_a      = take_hi ? a_q[7:4] : a_q[3:0];
  assign s_b      = take_hi ? b_q[7:4] : b_q[3:0];
  assign s_cin    = pass2 ? c1_q : (op_q == OP_SUB);
  assign res_full = hi_first ? {y1_q, s_y} : {s_y, y1_q};

  alu_slice4 u_slice (
    .a    (s_a),
    .b    (s_b),
    .op   (op_q),
    .cin  (s_cin),
    .y    (s_y),
    .cout (s_cout)
  );

  always_comb begin
    flags_nx.z = (res_full == 8'h00);
    flags_nx.n = res_full[7];
    flags_nx.c = s_cout;
    case (op_q)
      OP_ADD:  flags_nx.v = (a_q[7] == b_q[7]) && (res_full[7] != a_q[7]);
      OP_SUB:  flags_nx.v = (a_q[7] != b_q[7]) && (res_full[7] != a_q[7]);
      default: flags_nx.v = 1'b0;
    endcase
  end

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      y1_q    <= '0;
      c1_q    <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_e'(bus.cmd_op);
        a_q     <= op_a;
        b_q     <= bus.cmd_b;
        res_q   <= '0;
        flags_q <= '0;
        err_q   <= !legal;
      end
      if (state == ST_SLICE1) begin
        y1_q <= s_y;
        c1_q <= s_cout;
      end
      if (state == ST_SLICE2) begin
        res_q   <= res_full;
        flags_q <= flags_nx;
      end
    end
  end

`ifdef ALU_SEQ_ACC_EN
  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n)                                 acc_q <= '0;
    else if ((state == ST_DONE) && bus.res_ready) acc_q <= res_q;
  end
`endif

  assign bus.res_data  = res_q;
  assign bus.res_flags = flags_q;
  assign bus.res_err   = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: latency, per-op results and flags, hold,
// reset mid-op, masked opcode, and (with ALU_SEQ_ACC_EN) accumulator reuse.
module tb_alu_seq_ctrl;

  logic hz100 = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 hz100 = ~hz100;

  alu_seq_ctrl_if bus ();
  alu_seq_ctrl_if bm ();

  alu_seq_ctrl #(.MASK_OPS(8'hFF)) dut (
    .hz100   (hz100),
    .reset_n (reset_n),
    .bus     (bus)
  );

  alu_seq_ctrl #(.MASK_OPS(8'h7F)) dut_m (
    .hz100   (hz100),
    .reset_n (reset_n),
    .bus     (bm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Issues one command and leaves the DUT sitting in DONE with res_ready low.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic use_acc,
                        input logic [7:0] exp_d, input logic [3:0] exp_f);
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
`ifdef ALU_SEQ_ACC_EN
    bus.cmd_use_acc = use_acc;
`endif
    bus.cmd_valid = 1'b1;
    chk({tag, ".rdy"}, 32'(bus.cmd_ready), 32'd1);
    @(posedge hz100); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 8'hA5;
    bus.cmd_b     = 8'h5A;
`ifdef ALU_SEQ_ACC_EN
    bus.cmd_use_acc = 1'b0;
`endif
    chk({tag, ".lat1"}, {30'd0, bus.busy, bus.res_valid}, 32'b10);
    @(posedge hz100); #1;
    chk({tag, ".lat2"}, 32'(bus.res_valid), 32'd0);
    @(posedge hz100); #1;
    chk({tag, ".valid"}, 32'(bus.res_valid), 32'd1);
    chk({tag, ".data"}, 32'(bus.res_data), 32'(exp_d));
    chk({tag, ".flags"}, 32'(bus.res_flags), 32'(exp_f));
    chk({tag, ".err"}, 32'(bus.res_err), 32'd0);
    if (use_acc) begin end
  endtask

  task automatic release_res(input string tag);
    bus.res_ready = 1'b1;
    @(posedge hz100); #1;
    bus.res_ready = 1'b0;
    chk({tag, ".idle"}, {30'd0, bus.cmd_ready, bus.res_valid}, 32'b10);
  endtask

  initial begin
    logic seen;
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_a = 8'h00; bus.cmd_b = 8'h00;
    bus.res_ready = 1'b0;
    bm.cmd_valid  = 1'b0; bm.cmd_op  = 3'd0; bm.cmd_a  = 8'h00; bm.cmd_b  = 8'h00;
    bm.res_ready  = 1'b0;
`ifdef ALU_SEQ_ACC_EN
    bus.cmd_use_acc = 1'b0;
    bm.cmd_use_acc  = 1'b0;
`endif
    #12;
    chk("rst.ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.valid", 32'(bus.res_valid), 32'd0);
    chk("rst.outs", {19'd0, bus.res_err, bus.res_flags, bus.res_data}, 32'd0);
    @(negedge hz100);
    reset_n = 1'b1;
    @(posedge hz100); #1;

    run_op("add", 3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0110); release_res("add");
    run_op("sub0", 3'd1, 8'h10, 8'h10, 1'b0, 8'h00, 4'b1001); release_res("sub0");
    run_op("subm", 3'd1, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b0100); release_res("subm");
    run_op("shl", 3'd6, 8'h81, 8'h00, 1'b0, 8'h02, 4'b0001); release_res("shl");
    run_op("shr", 3'd7, 8'h81, 8'hFF, 1'b0, 8'h40, 4'b0001); release_res("shr");
    run_op("xor", 3'd5, 8'hF0, 8'hFF, 1'b0, 8'h0F, 4'b0000); release_res("xor");
    run_op("not", 3'd2, 8'h0F, 8'h33, 1'b0, 8'hF0, 4'b0100); release_res("not");
    run_op("and", 3'd3, 8'h3C, 8'h0F, 1'b0, 8'h0C, 4'b0000); release_res("and");
    run_op("or",  3'd4, 8'h81, 8'h10, 1'b0, 8'h91, 4'b0100); release_res("or");

    // Hold in DONE with cmd_* churning; result must not move.
    run_op("hold", 3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0110);
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = i[0];
      bus.cmd_op    = 3'(i);
      bus.cmd_a     = 8'(i * 37);
      @(posedge hz100); #1;
      chk("hold.data", {19'd0, bus.res_err, bus.res_flags, bus.res_data}, {19'd0, 1'b0, 4'b0110, 8'h80});
      chk("hold.hs", {30'd0, bus.res_valid, bus.cmd_ready}, 32'b10);
    end
    // Release edge with cmd_valid high must not also accept.
    bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b1;
    @(posedge hz100); #1;
    bus.res_ready = 1'b0;
    chk("hold.noacc", {30'd0, bus.cmd_ready, bus.busy}, 32'b10);
    bus.cmd_valid = 1'b0;

    // Reset during SLICE2.
    bus.cmd_op = 3'd0; bus.cmd_a = 8'h11; bus.cmd_b = 8'h22; bus.cmd_valid = 1'b1;
    @(posedge hz100); #1;
    bus.cmd_valid = 1'b0;
    @(posedge hz100); #1;
    reset_n = 1'b0;
    #1;
    chk("rs2.ready", {30'd0, bus.cmd_ready, bus.busy}, 32'b10);
    chk("rs2.outs", {18'd0, bus.res_valid, bus.res_err, bus.res_flags, bus.res_data}, 32'd0);
    @(negedge hz100);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge hz100); #1;
      if (bus.res_valid) seen = 1'b1;
    end
    chk("rs2.noresult", 32'(seen), 32'd0);

    // Reset while a nonzero result is held in DONE.
    run_op("rsd", 3'd4, 8'hC0, 8'h03, 1'b0, 8'hC3, 4'b0100);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rsd.outs", {18'd0, bus.res_valid, bus.res_err, bus.res_flags, bus.res_data}, 32'd0);
    chk("rsd.ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge hz100);
    reset_n = 1'b1;
    @(posedge hz100); #1;

    // Masked opcode on the 8'h7F instance.
    bm.cmd_op = 3'd7; bm.cmd_a = 8'h81; bm.cmd_valid = 1'b1;
    @(posedge hz100); #1;
    bm.cmd_valid = 1'b0;
    chk("mask.valid", 32'(bm.res_valid), 32'd1);
    chk("mask.err", 32'(bm.res_err), 32'd1);
    chk("mask.outs", {20'd0, bm.res_flags, bm.res_data}, 32'd0);
    bm.res_ready = 1'b1;
    @(posedge hz100); #1;
    bm.res_ready = 1'b0;
    chk("mask.idle", 32'(bm.cmd_ready), 32'd1);

`ifdef ALU_SEQ_ACC_EN
    run_op("acc1", 3'd0, 8'h05, 8'h03, 1'b0, 8'h08, 4'b0000); release_res("acc1");
    run_op("acc2", 3'd0, 8'h55, 8'h02, 1'b1, 8'h0A, 4'b0000); release_res("acc2");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter MASK_OPS, default 8'hFF, bit n set = opcode n legal.
REQ-002 SHALL have port hz100  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  controller accepts command.
REQ-006 SHALL have port cmd_op  input  3  opcode: 0 ADD, 1 SUB, 2 NOT, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR.
REQ-007 SHALL have port cmd_a  input  8  operand A.
REQ-008 SHALL have port cmd_b  input  8  operand B (ignored for NOT/SHL/SHR).
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_ready  input  1  consumer takes result.
REQ-011 SHALL have port res_data  output  8  8-bit result.
REQ-012 SHALL have port res_flags  output  4  {Z,N,V,C}.
REQ-013 SHALL have port res_err  output  1  illegal opcode was issued.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL execute every 8-bit op as two sequential passes through one shared 4-bit ALU slice.
REQ-016 SHALL use FSM states IDLE, SLICE1, SLICE2, DONE.
REQ-017 SHALL drive cmd_ready=1 only in IDLE.
REQ-018 SHALL capture op and operands on cmd_valid&cmd_ready, then go IDLE->SLICE1->SLICE2->DONE, one cycle each.
REQ-019 SHALL assert res_valid in DONE, exactly 3 cycles after the accepting edge.
REQ-020 SHALL process the low nibble first for all ops except SHR, which processes the high nibble first.
REQ-021 SHALL feed slice-1 carry-in as 0 for ADD and 1 for SUB (B inverted), and slice-2 carry-in as the slice-1 carry-out.
REQ-022 SHALL, for SHL, insert A[3] into result bit 4; for SHR, insert A[4] into result bit 3.
REQ-023 SHALL set flags: Z = (res_data==0); N = res_data[7]; V = signed overflow for ADD/SUB, else 0; C = carry out of bit 7 (ADD), no-borrow (SUB), A[7] (SHL), A[0] (SHR), 0 (logic ops).
REQ-024 SHALL hold res_data, res_flags, res_err stable while res_valid=1 and res_ready=0.
REQ-025 SHALL return DONE->IDLE on the edge where res_ready=1; no new command is accepted in that same cycle.
REQ-026 SHALL handle an opcode whose MASK_OPS bit is clear as follows: go IDLE->DONE in 1 cycle with res_data=0, res_flags=0, res_err=1.
REQ-027 SHALL ignore cmd_valid and all cmd_* changes outside IDLE.

Reset
REQ-028 SHALL, on reset_n=0 in any state, immediately force IDLE with res_valid=0, res_data=0, res_flags=0, res_err=0, busy=0, and cmd_ready=1.
REQ-029 SHALL discard any in-flight command on reset; no result is produced for it.

Configuration
REQ-030 SHALL, when ALU_SEQ_ACC_EN is defined, add input cmd_use_acc (1 bit) and an 8-bit accumulator holding the last delivered res_data (reset 0).
REQ-031 SHALL, when cmd_use_acc=1 at acceptance, use the accumulator as operand A in place of cmd_a.
REQ-032 SHALL, without ALU_SEQ_ACC_EN, omit cmd_use_acc and the accumulator and always use cmd_a.

Structure
REQ-033 SHALL have package alu_seq_pkg hold the opcode enum, FSM state enum, flag struct {Z,N,V,C} and nibble width constant.
REQ-034 SHALL place the 4-bit ALU in sub-module alu_slice4 (a, b, op, cin -> y, cout), combinational, instantiated once.

Verification
REQ-035 SHALL cover: ADD 0x7F+0x01 -> res_data 0x80, Z0 N1 V1 C0, res_valid 3 cycles after handshake.
REQ-036 SHALL cover: SUB 0x10-0x10 -> 0x00, Z1 N0 V0 C1; SUB 0x00-0x01 -> 0xFF, N1 C0.
REQ-037 SHALL cover: SHL 0x81 -> 0x02, C1; SHR 0x81 -> 0x40, C1; XOR 0xF0^0xFF -> 0x0F, C0.
REQ-038 SHALL cover: res_ready held low 5 cycles in DONE -> outputs stable, cmd_ready=0, toggling cmd_valid has no effect.
REQ-039 SHALL cover: reset_n pulsed low during SLICE2 -> all outputs 0 and cmd_ready=1 at once, and no res_valid afterwards.
REQ-040 SHALL cover: MASK_OPS=8'h7F, op 7 -> res_err=1, res_data 0x00 one cycle after accept; with ALU_SEQ_ACC_EN, ADD 0x05+0x03 followed by use_acc ADD b=0x02 -> 0x0A.
